// File: rtl/pps_qualifier.sv
// GPS 1PPS conditioner: synchronizes and glitch-filters PPS_IN, checks each interval
// against NOMINAL_PERIOD +/- TOLERANCE, and emits a fixed-width PPS_OUT only while locked.
module pps_qualifier #(
  parameter int NOMINAL_PERIOD = 10000000,
  parameter int TOLERANCE      = 1000,
  parameter int MIN_HIGH       = 4,
  parameter int LOCK_COUNT     = 3,
  parameter int OUT_WIDTH      = 8,
  parameter int COUNT_WIDTH    = 26
) (
  input  logic                   MAJOR_CLOCK,
  input  logic                   RESET_N,
  input  logic                   PPS_IN,
  output logic                   PPS_OUT,
  output logic                   LOCKED,
  output logic                   MISSED,
  output logic [COUNT_WIDTH-1:0] LAST_INTERVAL
);
  localparam int RW = $clog2(MIN_HIGH + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int PW = $clog2(OUT_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] LATE_E  = COUNT_WIDTH'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [COUNT_WIDTH-1:0] EARLY_E = COUNT_WIDTH'(NOMINAL_PERIOD - TOLERANCE - 1);
  localparam logic [RW-1:0] RUN_Q   = RW'(MIN_HIGH - 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MIN_HIGH);
  localparam logic [GW-1:0] G_MAX   = GW'(LOCK_COUNT);
  localparam logic [PW-1:0] P_LOAD  = PW'(OUT_WIDTH);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  typedef enum logic [1:0] {S_HUNT, S_ARMED, S_LOCKED} state_t;

  state_t                 r_state, w_state_n;
  logic [1:0]             r_sync;
  logic [RW-1:0]          r_run;
  logic                   r_armed;
  logic                   r_q;
  logic [COUNT_WIDTH-1:0] r_e;
  logic [GW-1:0]          r_g, w_g_n;
  logic [PW-1:0]          r_pcnt;
  logic                   r_pps, r_locked, r_missed;
  logic [COUNT_WIDTH-1:0] r_last;

  logic                   w_s, w_q_set, w_late, w_early, w_tmo;
  logic                   w_miss, w_fire, w_upd;
  logic [COUNT_WIDTH-1:0] w_interval;

  assign w_s        = r_sync[1];
  assign w_q_set    = w_s && r_armed && (r_run == RUN_Q);
  assign w_late     = (r_e >= LATE_E);
  assign w_early    = (r_e < EARLY_E);
  assign w_tmo      = !r_q && w_late;
  assign w_interval = (&r_e) ? r_e : r_e + 1'b1;

  // Synchronizer resets high so a pulse already in progress at reset release
  // must be seen low before the filter arms.
  always_ff @(posedge MAJOR_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync  <= 2'b11;
      r_run   <= '0;
      r_armed <= 1'b0;
      r_q     <= 1'b0;
      r_e     <= '0;
    end else begin
      r_sync <= {r_sync[0], PPS_IN};
      r_q    <= w_q_set;
      if (!w_s) begin
        r_run   <= '0;
        r_armed <= 1'b1;
      end else begin
        if (r_run != RUN_MAX) r_run <= r_run + 1'b1;
        if (w_q_set) r_armed <= 1'b0;
      end
      if (r_q)       r_e <= '0;
      else if (!(&r_e)) r_e <= r_e + 1'b1;
    end
  end

  always_ff @(posedge MAJOR_CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_HUNT;
    else          r_state <= w_state_n;
  end

  // A late Q (E+1 beyond the window) is a timeout plus a fresh reference edge.
  always_comb begin
    w_state_n = r_state;
    w_g_n     = r_g;
    w_miss    = 1'b0;
    w_fire    = 1'b0;
    w_upd     = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (r_q) begin
          w_state_n = S_ARMED;
          w_g_n     = '0;
        end
      end
      S_ARMED, S_LOCKED: begin
        if (r_q) begin
          w_upd = 1'b1;
          if (w_late) begin
            w_miss    = 1'b1;
            w_state_n = S_ARMED;
            w_g_n     = '0;
          end else if (w_early) begin
            w_state_n = S_ARMED;
            w_g_n     = '0;
          end else if (r_state == S_LOCKED || (int'(r_g) + 1 >= LOCK_COUNT - 1)) begin
            w_state_n = S_LOCKED;
            w_fire    = 1'b1;
            if (r_g != G_MAX) w_g_n = r_g + 1'b1;
          end else begin
            w_g_n = r_g + 1'b1;
          end
        end else if (w_tmo) begin
          w_miss    = 1'b1;
          w_state_n = S_HUNT;
          w_g_n     = '0;
        end
      end
      default: w_state_n = S_HUNT;
    endcase
  end

  always_ff @(posedge MAJOR_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_g      <= '0;
      r_locked <= 1'b0;
      r_missed <= 1'b0;
      r_last   <= '0;
      r_pcnt   <= '0;
      r_pps    <= 1'b0;
    end else begin
      r_g      <= w_g_n;
      r_locked <= (w_state_n == S_LOCKED);
      r_missed <= w_miss;
      if (w_upd) r_last <= w_interval;
      if (w_fire) begin
        r_pcnt <= P_LOAD;
        r_pps  <= 1'b1;
      end else if (w_state_n != S_LOCKED || r_pcnt <= P_ONE) begin
        r_pcnt <= '0;
        r_pps  <= 1'b0;
      end else begin
        r_pcnt <= r_pcnt - 1'b1;
      end
    end
  end

  assign PPS_OUT       = r_pps;
  assign LOCKED        = r_locked;
  assign MISSED        = r_missed;
  assign LAST_INTERVAL = r_last;
endmodule

// File: tb/tb_pps_qualifier.sv
// Directed bench for pps_qualifier with a short nominal period (100 +/- 5 cycles).
module tb_pps_qualifier;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pps_in = 1'b0;
  logic          pps_out, locked, missed;
  logic [CW-1:0] last_int;

  int checks = 0;
  int failures = 0;
  int p_first, p_len, p_miss, p_miss_at, p_lock_miss;

  always #5 clk = ~clk;

  pps_qualifier #(
    .NOMINAL_PERIOD(100), .TOLERANCE(5), .MIN_HIGH(3),
    .LOCK_COUNT(3), .OUT_WIDTH(4), .COUNT_WIDTH(CW)
  ) dut (
    .MAJOR_CLOCK(clk), .RESET_N(rst_n), .PPS_IN(pps_in),
    .PPS_OUT(pps_out), .LOCKED(locked), .MISSED(missed), .LAST_INTERVAL(last_int)
  );

  // One pulse: pin high for hi cycles, next rise per cycles later. Offsets are
  // edges after the cycle the pin was driven high.
  task automatic pulse(input int hi, input int per);
    p_first = -1; p_len = 0; p_miss = 0; p_miss_at = -1; p_lock_miss = -1;
    for (int t = 0; t < per; t++) begin
      pps_in = (t < hi);
      @(posedge clk); #1;
      if (pps_out) begin
        if (p_first < 0) p_first = t + 1;
        p_len++;
      end
      if (missed) begin
        p_miss++;
        p_miss_at = t + 1;
        p_lock_miss = int'(locked);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int t = 0; t < 12; t++) begin
      pps_in = ((t / 2) % 2 == 1);
      @(posedge clk); #1;
      checks++;
      if ({pps_out, locked, missed, last_int} !== '0) begin
        failures++; $display("FAIL reset_hold cyc=%0d got=%b/%b/%b/%0d exp=0", t, pps_out, locked, missed, last_int);
      end
    end
    pps_in = 1'b0;
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin @(posedge clk); #1; end
    checks++;
    if ({pps_out, locked, missed, last_int} !== '0) begin
      failures++; $display("FAIL reset_release got=%b/%b/%b/%0d exp=0", pps_out, locked, missed, last_int);
    end
  endtask

  task automatic test_glitch;
    for (int n = 0; n < 3; n++) begin
      pulse(2, 100);
      checks++;
      if (p_len !== 0 || p_miss !== 0 || locked !== 1'b0 || last_int !== 8'd0) begin
        failures++; $display("FAIL glitch%0d pps=%0d miss=%0d lock=%b li=%0d exp all 0", n, p_len, p_miss, locked, last_int);
      end
    end
  endtask

  task automatic test_lock;
    pulse(10, 100);
    checks++;
    if (p_len !== 0 || locked !== 1'b0 || last_int !== 8'd0) begin
      failures++; $display("FAIL lock_p1 pps=%0d lock=%b li=%0d exp 0/0/0", p_len, locked, last_int);
    end
    pulse(10, 100);
    checks++;
    if (p_len !== 0 || locked !== 1'b0 || last_int !== 8'd100) begin
      failures++; $display("FAIL lock_p2 pps=%0d lock=%b li=%0d exp 0/0/100", p_len, locked, last_int);
    end
    pulse(10, 100);
    checks++;
    if (locked !== 1'b1 || last_int !== 8'd100) begin
      failures++; $display("FAIL lock_p3 lock=%b li=%0d exp 1/100", locked, last_int);
    end
    checks++;
    if (p_first !== 6 || p_len !== 4) begin
      failures++; $display("FAIL lock_p3_pps first=%0d len=%0d exp 6/4", p_first, p_len);
    end
  endtask

  task automatic test_window;
    pulse(10, 95);
    checks++;
    if (p_first !== 6 || p_len !== 4 || locked !== 1'b1 || last_int !== 8'd100) begin
      failures++; $display("FAIL win100 first=%0d len=%0d lock=%b li=%0d exp 6/4/1/100", p_first, p_len, locked, last_int);
    end
    pulse(10, 105);
    checks++;
    if (p_first !== 6 || p_len !== 4 || locked !== 1'b1 || last_int !== 8'd95) begin
      failures++; $display("FAIL win95 first=%0d len=%0d lock=%b li=%0d exp 6/4/1/95", p_first, p_len, locked, last_int);
    end
    pulse(10, 94);
    checks++;
    if (p_first !== 6 || p_len !== 4 || locked !== 1'b1 || last_int !== 8'd105) begin
      failures++; $display("FAIL win105 first=%0d len=%0d lock=%b li=%0d exp 6/4/1/105", p_first, p_len, locked, last_int);
    end
    pulse(10, 100);
    checks++;
    if (p_len !== 0 || p_miss !== 0 || locked !== 1'b0 || last_int !== 8'd94) begin
      failures++; $display("FAIL win94 pps=%0d miss=%0d lock=%b li=%0d exp 0/0/0/94", p_len, p_miss, locked, last_int);
    end
    // Early edge became the reference: next interval is measured from it.
    pulse(10, 100);
    checks++;
    if (p_len !== 0 || locked !== 1'b0 || last_int !== 8'd100) begin
      failures++; $display("FAIL early_ref pps=%0d lock=%b li=%0d exp 0/0/100", p_len, locked, last_int);
    end
    pulse(10, 100);
    checks++;
    if (p_len !== 4 || locked !== 1'b1) begin
      failures++; $display("FAIL relock pps=%0d lock=%b exp 4/1", p_len, locked);
    end
  endtask

  task automatic test_timeout;
    pulse(10, 200);
    checks++;
    if (p_first !== 6 || p_len !== 4) begin
      failures++; $display("FAIL tmo_pps first=%0d len=%0d exp 6/4", p_first, p_len);
    end
    checks++;
    if (p_miss !== 1 || p_miss_at !== 112 || p_lock_miss !== 0) begin
      failures++; $display("FAIL tmo_missed cnt=%0d at=%0d lock=%0d exp 1/112/0", p_miss, p_miss_at, p_lock_miss);
    end
    checks++;
    if (locked !== 1'b0 || last_int !== 8'd100) begin
      failures++; $display("FAIL tmo_state lock=%b li=%0d exp 0/100", locked, last_int);
    end
    pulse(10, 98);
    checks++;
    if (p_len !== 0 || p_miss !== 0 || locked !== 1'b0 || last_int !== 8'd100) begin
      failures++; $display("FAIL tmo_rearm pps=%0d miss=%0d lock=%b li=%0d exp 0/0/0/100", p_len, p_miss, locked, last_int);
    end
    pulse(10, 100);
    checks++;
    if (p_len !== 0 || locked !== 1'b0 || last_int !== 8'd98) begin
      failures++; $display("FAIL tmo_armed pps=%0d lock=%b li=%0d exp 0/0/98", p_len, locked, last_int);
    end
    pulse(10, 106);
    checks++;
    if (p_len !== 4 || locked !== 1'b1) begin
      failures++; $display("FAIL tmo_relock pps=%0d lock=%b exp 4/1", p_len, locked);
    end
  endtask

  task automatic test_late;
    pulse(10, 100);
    checks++;
    if (p_miss !== 1 || p_miss_at !== 6 || p_lock_miss !== 0) begin
      failures++; $display("FAIL late_missed cnt=%0d at=%0d lock=%0d exp 1/6/0", p_miss, p_miss_at, p_lock_miss);
    end
    checks++;
    if (p_len !== 0 || locked !== 1'b0 || last_int !== 8'd106) begin
      failures++; $display("FAIL late_state pps=%0d lock=%b li=%0d exp 0/0/106", p_len, locked, last_int);
    end
    pulse(10, 100);
    checks++;
    if (p_len !== 0 || locked !== 1'b0 || last_int !== 8'd100) begin
      failures++; $display("FAIL late_p1 pps=%0d lock=%b li=%0d exp 0/0/100", p_len, locked, last_int);
    end
    pulse(10, 100);
    checks++;
    if (p_len !== 4 || p_first !== 6 || locked !== 1'b1) begin
      failures++; $display("FAIL late_relock pps=%0d first=%0d lock=%b exp 4/6/1", p_len, p_first, locked);
    end
  endtask

  task automatic test_async_reset;
    int bad;
    bad = 0;
    for (int t = 0; t < 100; t++) begin
      pps_in = (t < 25);
      @(posedge clk); #1;
      if (t + 1 == 7) begin
        checks++;
        if (pps_out !== 1'b1 || locked !== 1'b1) begin
          failures++; $display("FAIL arst_pre pps=%b lock=%b exp 1/1", pps_out, locked);
        end
        #3; rst_n = 1'b0; #1;
        checks++;
        if ({pps_out, locked, missed, last_int} !== '0) begin
          failures++; $display("FAIL arst_async got=%b/%b/%b/%0d exp=0", pps_out, locked, missed, last_int);
        end
      end
      if (t + 1 == 10) rst_n = 1'b1;
      if (t + 1 > 7 && (pps_out || locked || missed || last_int != 0)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL arst_quiet active_cycles=%0d exp=0", bad);
    end
    // The pulse straddling reset release must not have become a reference.
    pulse(10, 100);
    checks++;
    if (p_len !== 0 || locked !== 1'b0 || last_int !== 8'd0) begin
      failures++; $display("FAIL arst_hunt pps=%0d lock=%b li=%0d exp 0/0/0", p_len, locked, last_int);
    end
    pulse(10, 100);
    checks++;
    if (locked !== 1'b0 || last_int !== 8'd100) begin
      failures++; $display("FAIL arst_armed lock=%b li=%0d exp 0/100", locked, last_int);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_lock();
    test_window();
    test_timeout();
    test_late();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
